// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// Latency: n/a (signal bundle only).
// Backpressure: in_valid/in_ready handshake on the byte stream; the write port has none.
// Ports: in_valid/in_data/in_ready (stream), imem_we/imem_addr/imem_wdata (memory write).
interface imem_loader_if #(
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // master: the byte source that also observes the memory write port
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  // slave: the loader itself
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: assembles a big-endian byte stream into 32-bit words written to imem.
// Latency: imem_we one cycle after a word's 4th byte; done/core_rst one cycle after the checksum byte.
// Backpressure: in_ready is a pure state decode, so accepts one byte per cycle while loading.
// Ports: clk, rst (async active-low), bus (stream in + imem write out),
//        core_rst (0 holds core in reset), done / error (sticky status).
module imem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  imem_loader_if.slave   bus,
  output logic           core_rst,
  output logic           done,
  output logic           error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_HI = 3'd1,
    S_CNT_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [ADDR_W:0] WIDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q,  state_d;
  logic [15:0]       cnt_q,    cnt_d;     // word count N from the header
  logic [ADDR_W:0]   widx_q,   widx_d;    // one bit wider so DEPTH words never wrap
  logic [1:0]        bidx_q,   bidx_d;    // byte position within the current word
  logic [7:0]        csum_q,   csum_d;
  logic [23:0]       buf_q,    buf_d;     // first three bytes of the word in flight
  logic              we_q,     we_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [31:0]       wdata_q,  wdata_d;

  logic              ready;
  logic              accept;
  logic [15:0]       n_full;
  logic [15:0]       last_idx;
  logic [15:0]       widx_ext;

  // Ready depends on state only, never on in_valid, so there is no comb loop
  // through the source.
  assign ready  = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                  (state_q == S_DATA)   || (state_q == S_CHECK);
  assign accept = bus.in_valid && ready;

  assign n_full   = {cnt_q[15:8], bus.in_data};
  assign last_idx = cnt_q - 16'd1;
  assign widx_ext = 16'(widx_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      csum_q  <= '0;
      buf_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      csum_q  <= csum_d;
      buf_q   <= buf_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    csum_d  = csum_q;
    buf_d   = buf_q;
    we_d    = 1'b0;           // write strobe is a single-cycle pulse
    addr_d  = addr_q;         // address/data hold between writes
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_CNT_HI;
      end

      S_CNT_HI: begin
        if (accept) begin
          cnt_d   = {bus.in_data, cnt_q[7:0]};
          state_d = S_CNT_LO;
        end
      end

      S_CNT_LO: begin
        if (accept) begin
          cnt_d = n_full;
          if ((n_full == 16'd0) || (n_full > 16'(DEPTH))) begin
            state_d = S_ERR;
          end else begin
            widx_d  = '0;
            bidx_d  = '0;
            csum_d  = '0;
            buf_d   = '0;
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          buf_d  = {buf_q[15:0], bus.in_data};
          csum_d = csum_q ^ bus.in_data;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = widx_q[ADDR_W-1:0];
            wdata_d = {buf_q, bus.in_data};
            widx_d  = widx_q + WIDX_ONE;
            // The last word's write still lands next cycle while CHECK waits
            // for the checksum byte.
            if (widx_ext == last_idx) begin
              state_d = S_CHECK;
            end
          end
        end
      end

      S_CHECK: begin
        if (accept) begin
          state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
        end
      end

      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready   = ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

  // DONE and ERR are distinct states, so done and error are mutually exclusive;
  // the core is released only once the image has verified.
  assign done     = (state_q == S_DONE);
  assign error    = (state_q == S_ERR);
  assign core_rst = (state_q == S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: scoreboard of expected memory writes plus end-of-load status.
// Latency: n/a.
// Backpressure: driver honours in_ready and can insert idle cycles on in_valid.
module tb_imem_loader;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic core_rst, done, error;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .core_rst (core_rst),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stim[$];
  int         checks = 0;
  int         errors = 0;
  int         wr_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the head of the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (rst && bus.imem_we) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 64'(bus.imem_addr), 64'(e.addr));
        chk("write_data", 64'(bus.imem_wdata), 64'(e.data));
      end
    end
  end

  // Reference: parse the byte image by the stream rules, queue the writes it
  // implies and return whether the load should end in done (1) or error (0).
  function automatic bit model(output int nwr);
    int         n;
    logic [7:0] x;
    wr_t        w;
    nwr = 0;
    n   = 256 * int'(stim[0]) + int'(stim[1]);
    if (n == 0 || n > DEPTH) return 1'b0;
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      w.addr = ADDR_W'(k);
      w.data = {stim[2+4*k], stim[3+4*k], stim[4+4*k], stim[5+4*k]};
      exp_q.push_back(w);
      for (int j = 0; j < 4; j++) x = x ^ stim[2+4*k+j];
    end
    nwr = n;
    return stim[2+4*n] == x;
  endfunction

  // Builds an image of n words (random or 0x1000_0000+k), optionally corrupting
  // the checksum. Illegal counts produce a header-only stream.
  function automatic void mk_img(input int n, input bit rnd, input bit bad_cs);
    logic [31:0] w;
    logic [7:0]  x;
    stim.delete();
    stim.push_back(8'(n >> 8));
    stim.push_back(8'(n));
    if (n == 0 || n > DEPTH) return;
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      w = rnd ? $urandom : (32'h1000_0000 + 32'(k));
      for (int j = 3; j >= 0; j--) begin
        stim.push_back(8'(w >> (8 * j)));
        x = x ^ 8'(w >> (8 * j));
      end
    end
    if (bad_cs) x = x ^ 8'(1 << $urandom_range(7));
    stim.push_back(x);
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap_pct, input int limit,
                           output bit acc);
    bit rdy;
    acc = 1'b0;
    if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
    end
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) begin
        acc = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #1;
    chk("reset_outputs", 64'({bus.imem_we, done, error, core_rst, bus.in_ready}), 64'd0);
    exp_q.delete();
    wr_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_stream(input string name, input int gap_pct);
    bit exp_done;
    bit acc;
    int nwr;
    do_reset();
    exp_done = model(nwr);
    for (int i = 0; i < stim.size(); i++) begin
      send_byte(stim[i], gap_pct, 40, acc);
      if (!acc) begin
        chk({name, "_byte_accept"}, 64'(i), 64'(stim.size()));
        break;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    // {done, error, core_rst, in_ready} one cycle after the final byte
    chk({name, "_status"}, 64'({done, error, core_rst, bus.in_ready}),
        exp_done ? 64'd10 : 64'd4);
    chk({name, "_write_count"}, 64'(wr_cnt), 64'(nwr));
    chk({name, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bit acc;
    int n;
    int r;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Golden two-word image, correct checksum
    stim = '{8'h00, 8'h02, 8'h20, 8'h0A, 8'h00, 8'h05, 8'h20, 8'h0B, 8'h00, 8'h07, 8'h03};
    run_stream("basic", 0);

    // Same image, bad checksum: writes still happen, then error
    stim = '{8'h00, 8'h02, 8'h20, 8'h0A, 8'h00, 8'h05, 8'h20, 8'h0B, 8'h00, 8'h07, 8'h04};
    run_stream("bad_csum", 0);

    // Illegal word counts
    stim = '{8'h00, 8'h00};
    run_stream("count_zero", 0);
    stim = '{8'h00, 8'h21};
    run_stream("count_33", 0);

    // Gapped valid, then bytes offered after done must be refused
    stim = '{8'h00, 8'h02, 8'h20, 8'h0A, 8'h00, 8'h05, 8'h20, 8'h0B, 8'h00, 8'h07, 8'h03};
    run_stream("gapped", 100);
    send_byte(8'hAA, 0, 8, acc);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("after_done_accept", 64'(acc), 64'd0);
    chk("after_done_writes", 64'(wr_cnt), 64'd2);
    chk("after_done_status", 64'({done, error, core_rst}), 64'd5);

    // Reset mid-load right after the first word's last byte
    do_reset();
    void'(model(n));
    for (int i = 0; i < 6; i++) begin
      send_byte(stim[i], 0, 40, acc);
      if (!acc) chk("midreset_byte_accept", 64'(i), 64'd6);
    end
    #1;
    rst = 1'b0;
    #1;
    chk("midreset_outputs",
        64'({bus.imem_we, done, error, core_rst, bus.in_ready}), 64'd0);
    @(negedge clk);
    chk("midreset_no_write", 64'(wr_cnt), 64'd0);
    exp_q.delete();
    run_stream("after_midreset", 0);

    // Full-depth image, back to back
    mk_img(DEPTH, 1'b0, 1'b0);
    run_stream("full_depth", 0);

    // Randomised images: legal, zero and oversized counts, occasional bad checksum
    for (int it = 0; it < 20; it++) begin
      r = int'($urandom_range(99));
      if (r < 10)      n = 0;
      else if (r < 20) n = int'($urandom_range(33, 600));
      else             n = int'($urandom_range(1, DEPTH));
      mk_img(n, 1'b1, $urandom_range(3) == 0);
      run_stream("random", int'($urandom_range(60)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
